// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: default widths, register count and requester ids shared by the register write arbiter
package reg_arb_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int NUM_REGS = 1 << ADDR_W_DEF;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;
endpackage

// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: requester handshakes, reservation, busy query and register bank write port
interface reg_write_arbiter_if #(parameter int DATA_W = 8, parameter int ADDR_W = 3);
  logic a_valid, a_ready, b_valid, b_ready, rsv_valid, qry_busy1, qry_busy2, RegWrite;
  logic [ADDR_W-1:0] a_addr, b_addr, rsv_addr, qry_addr1, qry_addr2, WriteReg;
  logic [DATA_W-1:0] a_data, b_data, Write_data;
  logic [(1<<ADDR_W)-1:0] busy_vec;
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, rsv_valid, rsv_addr, qry_addr1, qry_addr2,
    input a_ready, b_ready, qry_busy1, qry_busy2, busy_vec, RegWrite, WriteReg, Write_data
  );
  modport slave (
    input a_valid, a_addr, a_data, b_valid, b_addr, b_data, rsv_valid, rsv_addr, qry_addr1, qry_addr2,
    output a_ready, b_ready, qry_busy1, qry_busy2, busy_vec, RegWrite, WriteReg, Write_data
  );
endinterface

// File: rtl/reg_write_arbiter_rr.sv
// rr_arbiter2: two-way round-robin grant with a last-grant pointer that moves only on a grant
module rr_arbiter2 import reg_arb_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  req_id_e last_q, last_d;
  always_comb begin
    grant = rst ? 2'b00 : (&req) ? (last_q == REQ_A ? 2'b10 : 2'b01) : req;
    last_d = grant[1] ? REQ_B : grant[0] ? REQ_A : last_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= REQ_B;
    else last_q <= last_d;
endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin writeback arbiter with busy scoreboard; REGARB_BUSY_BYPASS_EN clears query busy in the completing cycle
module reg_write_arbiter import reg_arb_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic clk,
  input logic rst,
  reg_write_arbiter_if.slave bus
);
  logic [1:0] grant;
  logic xfer;
  logic [ADDR_W-1:0] xfer_addr, write_reg_q, write_reg_d;
  logic [DATA_W-1:0] xfer_data, write_data_q, write_data_d;
  logic reg_write_q, reg_write_d;
  logic [(1<<ADDR_W)-1:0] busy_q, busy_d;
  rr_arbiter2 u_rr (.clk(clk), .rst(rst), .req({bus.b_valid, bus.a_valid}), .grant(grant));
  assign xfer = |grant;
  assign xfer_addr = grant[1] ? bus.b_addr : bus.a_addr;
  assign xfer_data = grant[1] ? bus.b_data : bus.a_data;
  always_comb begin
    reg_write_d = xfer;
    write_reg_d = xfer ? xfer_addr : write_reg_q;
    write_data_d = xfer ? xfer_data : write_data_q;
    busy_d = busy_q;
    if (xfer) busy_d[xfer_addr] = 1'b0;
    if (bus.rsv_valid) busy_d[bus.rsv_addr] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      reg_write_q <= 1'b0;
      write_reg_q <= '0;
      write_data_q <= '0;
      busy_q <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      write_reg_q <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q <= busy_d;
    end
  assign bus.a_ready = grant[0];
  assign bus.b_ready = grant[1];
  assign bus.RegWrite = reg_write_q;
  assign bus.WriteReg = write_reg_q;
  assign bus.Write_data = write_data_q;
  assign bus.busy_vec = busy_q;
`ifdef REGARB_BUSY_BYPASS_EN
  assign bus.qry_busy1 = busy_q[bus.qry_addr1] &
    ~(xfer && xfer_addr == bus.qry_addr1 && !(bus.rsv_valid && bus.rsv_addr == bus.qry_addr1));
  assign bus.qry_busy2 = busy_q[bus.qry_addr2] &
    ~(xfer && xfer_addr == bus.qry_addr2 && !(bus.rsv_valid && bus.rsv_addr == bus.qry_addr2));
`else
  assign bus.qry_busy1 = busy_q[bus.qry_addr1];
  assign bus.qry_busy2 = busy_q[bus.qry_addr2];
`endif
endmodule
